// File: rtl/fb_stream_pkg.sv
//------------------------------------------------------------------------------
// fb_stream_pkg : shared types and constants for the descriptor stream scheduler
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fb_stream_pkg;

  localparam int DESC_W  = 256;
  localparam int COORD_W = 11;

  typedef struct packed {
    logic [1:0]         pad;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
    logic [DESC_W-1:0]  desc;
  } desc_beat_t;

  // Stream beat width is derived from the beat layout so the two cannot diverge
  localparam int AXIS_W = $bits(desc_beat_t);

  typedef enum logic [1:0] {
    STREAM = 2'd0,
    DRAIN  = 2'd1,
    EOF    = 2'd2
  } sched_state_t;

  localparam int MRK_ID_LSB  = 0;
  localparam int MRK_ID_W    = 8;
  localparam int MRK_CNT_LSB = 8;
  localparam int MRK_CNT_W   = 10;

endpackage

`default_nettype wire

// File: rtl/fb_desc_fifo.sv
//------------------------------------------------------------------------------
// fb_desc_fifo : synchronous descriptor FIFO with a registered head beat
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fb_desc_fifo
  import fb_stream_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  desc_beat_t din,
  output desc_beat_t head,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  desc_beat_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   rd_next;
  logic [AW:0]     count;

  assign rd_next = rd_ptr + PTR_ONE;
  assign empty   = (count == '0);
  assign full    = (count == CNT_MAX);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // head always mirrors the oldest entry and reads as zero when the queue is empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_next;

      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      if (pop) begin
        if (count > CNT_ONE) head <= mem[rd_next];
        else if (push)       head <= din;
        else                 head <= '0;
      end else if (push && empty) begin
        head <= din;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fb_desc_stream_scheduler.sv
//------------------------------------------------------------------------------
// fb_desc_stream_scheduler : buffers descriptors onto AXI4-Stream with frame
// budget and end-of-frame marker; FB_STREAM_FRAME_ID_EN adds marker payload.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fb_desc_stream_scheduler
  import fb_stream_pkg::*;
#(
  parameter int DESC_WIDTH  = DESC_W,
  parameter int COORD_WIDTH = COORD_W,
  parameter int AXIS_WIDTH  = AXIS_W,
  parameter int MAX_CORNERS = 1000,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               frame_start,
  input  logic                               desc_valid,
  input  logic [DESC_WIDTH-1:0]              desc_data,
  input  logic [COORD_WIDTH-1:0]             desc_x,
  input  logic [COORD_WIDTH-1:0]             desc_y,
  output logic [AXIS_WIDTH-1:0]              m_axis_tdata,
  output logic                               m_axis_tvalid,
  output logic                               m_axis_tlast,
  input  logic                               m_axis_tready,
  output logic [15:0]                        dropped_count,
  output logic [$clog2(MAX_CORNERS+1)-1:0]   frame_corner_count,
  output logic                               busy
);

  localparam int CW = $clog2(MAX_CORNERS+1);
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_CORNERS);
  localparam logic [CW-1:0] CW_ONE = CW'(1);

  sched_state_t state;
  sched_state_t state_nxt;

  desc_beat_t            in_beat;
  desc_beat_t            head;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;
  logic                  marker_hs;
  logic [CW-1:0]         budget;
  logic [AXIS_WIDTH-1:0] marker;
  logic [MRK_ID_W-1:0]   id_field;
  logic [MRK_CNT_W-1:0]  cnt_field;

  assign in_beat = '{pad: 2'b00, y: desc_y, x: desc_x, desc: desc_data};

  fb_desc_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (in_beat),
    .head  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= STREAM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    push          = 1'b0;
    pop           = 1'b0;
    marker_hs     = 1'b0;
    m_axis_tvalid = !fifo_empty;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = head;
    busy          = (state != STREAM);
    case (state)
      STREAM: begin
        push = desc_valid && !fifo_full && (budget < MAX_C);
        pop  = !fifo_empty && m_axis_tready;
        if (frame_start) state_nxt = DRAIN;
      end
      DRAIN: begin
        pop = !fifo_empty && m_axis_tready;
        if (fifo_empty) state_nxt = EOF;
      end
      EOF: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tdata  = marker;
        marker_hs     = m_axis_tready;
        if (m_axis_tready) state_nxt = STREAM;
      end
      default: state_nxt = STREAM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      budget             <= '0;
      frame_corner_count <= '0;
      dropped_count      <= '0;
    end else begin
      if (marker_hs) begin
        frame_corner_count <= budget;
        budget             <= '0;
      end else if (push) begin
        budget <= budget + CW_ONE;
      end
      if (desc_valid && !push && (dropped_count != 16'hFFFF))
        dropped_count <= dropped_count + 16'd1;
    end
  end

`ifdef FB_STREAM_FRAME_ID_EN
  logic [MRK_ID_W-1:0] frame_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         frame_id <= '0;
    else if (marker_hs) frame_id <= frame_id + MRK_ID_W'(1);
  end

  // Count field is clipped rather than truncated when the budget exceeds 10 bits
  always_comb begin
    id_field = frame_id;
    if (32'(budget) > ((2 ** MRK_CNT_W) - 1)) cnt_field = '1;
    else                                      cnt_field = MRK_CNT_W'(budget);
  end
`else
  assign id_field  = '0;
  assign cnt_field = '0;
`endif

  always_comb begin
    marker                              = '0;
    marker[MRK_ID_LSB  +: MRK_ID_W]     = id_field;
    marker[MRK_CNT_LSB +: MRK_CNT_W]    = cnt_field;
  end

endmodule

`default_nettype wire

// File: tb/tb_fb_desc_stream_scheduler.sv
//------------------------------------------------------------------------------
// tb_fb_desc_stream_scheduler : randomized bench against a queue-based frame model
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fb_desc_stream_scheduler;

  localparam int TB_MAX = 24;
  localparam int DEPTH  = 16;
  localparam int CW     = $clog2(TB_MAX+1);

  logic           clk = 1'b0;
  logic           rst_n;
  logic           frame_start;
  logic           desc_valid;
  logic [255:0]   desc_data;
  logic [10:0]    desc_x;
  logic [10:0]    desc_y;
  logic [279:0]   m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tlast;
  logic           m_axis_tready;
  logic [15:0]    dropped_count;
  logic [CW-1:0]  frame_corner_count;
  logic           busy;

  int checks = 0;
  int errors = 0;

  // Model of the frame: queued beats, closing/marker phases, counters
  logic [279:0] mq[$];
  bit           closing;
  bit           marker;
  int           acc;
  int           fcc;
  int           dropped;
  int           fid;

  always #5 clk = ~clk;

  fb_desc_stream_scheduler #(
    .MAX_CORNERS (TB_MAX),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .frame_start        (frame_start),
    .desc_valid         (desc_valid),
    .desc_data          (desc_data),
    .desc_x             (desc_x),
    .desc_y             (desc_y),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tlast       (m_axis_tlast),
    .m_axis_tready      (m_axis_tready),
    .dropped_count      (dropped_count),
    .frame_corner_count (frame_corner_count),
    .busy               (busy)
  );

  task automatic check_eq(input string tag, input logic [279:0] got, input logic [279:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [279:0] marker_payload();
    logic [279:0] p;
    p = '0;
`ifdef FB_STREAM_FRAME_ID_EN
    p[7:0]  = 8'(fid % 256);
    p[17:8] = 10'((acc > 1023) ? 1023 : acc);
`endif
    return p;
  endfunction

  task automatic model_reset();
    mq.delete();
    closing = 0;
    marker  = 0;
    acc     = 0;
    fcc     = 0;
    dropped = 0;
    fid     = 0;
  endtask

  task automatic check_outputs();
    logic [279:0] exp_data;
    if (marker)            exp_data = marker_payload();
    else if (mq.size() > 0) exp_data = mq[0];
    else                   exp_data = '0;
    check_eq("tvalid", m_axis_tvalid, marker || (mq.size() > 0));
    check_eq("tlast", m_axis_tlast, marker);
    check_eq("tdata", m_axis_tdata, exp_data);
    check_eq("busy", busy, closing || marker);
    check_eq("dropped", dropped_count, dropped);
    check_eq("frame_cnt", frame_corner_count, fcc);
  endtask

  // One clock: check current outputs, drive inputs, advance the model
  task automatic step(input bit v, input bit fs, input bit rdy,
                      input logic [10:0] x, input logic [10:0] y);
    logic [255:0] d;
    bit           do_pop;
    bit           accept;
    int           n0;
    @(negedge clk);
    check_outputs();
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    desc_valid    = v;
    frame_start   = fs;
    m_axis_tready = rdy;
    desc_x        = x;
    desc_y        = y;
    desc_data     = d;

    n0     = mq.size();
    do_pop = !marker && (n0 > 0) && rdy;
    accept = v && !closing && !marker && (n0 < DEPTH) && (acc < TB_MAX);
    if (accept) begin
      mq.push_back({2'b00, y, x, d});
      acc++;
    end else if (v && dropped < 65535) begin
      dropped++;
    end
    if (do_pop) void'(mq.pop_front());

    if (marker) begin
      if (rdy) begin
        marker = 0;
        fcc    = acc;
        acc    = 0;
        fid    = (fid + 1) % 256;
      end
    end else if (closing) begin
      if (n0 == 0) begin
        closing = 0;
        marker  = 1;
      end
    end else if (fs) begin
      closing = 1;
    end
  endtask

  task automatic rstep(input bit v, input bit fs, input bit rdy);
    step(v, fs, rdy, 11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)));
  endtask

  task automatic drain(input int rdy_pct);
    int n = 0;
    while ((closing || marker || mq.size() > 0) && n < 500) begin
      rstep(0, 0, $urandom_range(0, 99) < rdy_pct);
      n++;
    end
    check_eq("drain_timeout", n >= 500, 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    frame_start   = 1'b0;
    desc_valid    = 1'b0;
    desc_data     = '0;
    desc_x        = '0;
    desc_y        = '0;
    m_axis_tready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Five descriptors in one frame, then close it
    for (int i = 1; i <= 5; i++) step(1, 0, 1, 11'(i), 11'd7);
    rstep(0, 1, 1);
    drain(100);
    rstep(0, 0, 1);
    check_eq("frame_cnt_5", frame_corner_count, 5);

    // Back-pressure: 20 arrivals into a 16-deep queue while stalled
    for (int i = 0; i < 20; i++) rstep(1, 0, 0);
    for (int i = 0; i < 20; i++) rstep(0, 0, 0);
    rstep(0, 0, 0);
    check_eq("stall_drops", dropped_count, 4);
    rstep(0, 1, 1);
    drain(100);

    // Budget: 30 arrivals in one frame, only TB_MAX pass; next frame is fresh
    for (int i = 0; i < 30; i++) rstep(1, 0, 1);
    rstep(0, 1, 1);
    drain(100);
    for (int i = 0; i < 2; i++) rstep(1, 0, 1);
    rstep(0, 1, 1);
    drain(100);
    rstep(0, 0, 1);
    check_eq("frame_cnt_2", frame_corner_count, 2);

    // Close with 4 queued, toggling ready, repeated frame_start and late arrivals
    for (int i = 0; i < 4; i++) rstep(1, 0, 0);
    rstep(0, 1, 0);
    for (int i = 0; i < 16; i++) rstep(i % 3 == 0, i % 4 == 1, i % 2 == 0);
    drain(100);

    // Asynchronous reset in the middle of a drain
    for (int i = 0; i < 3; i++) rstep(1, 0, 0);
    rstep(0, 1, 0);
    rstep(0, 0, 0);
    rstep(0, 0, 0);
    #2 rst_n = 1'b0;
    desc_valid  = 1'b0;
    frame_start = 1'b0;
    #1;
    model_reset();
    check_eq("rst_tvalid", m_axis_tvalid, 0);
    check_eq("rst_tdata", m_axis_tdata, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_dropped", dropped_count, 0);
    check_eq("rst_frame_cnt", frame_corner_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) rstep(0, 0, 1);

    // Three short frames (marker payload numbering when enabled)
    for (int f = 0; f < 3; f++) begin
      rstep(1, 0, 1);
      rstep(1, 0, 1);
      rstep(0, 1, 1);
      drain(100);
    end

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      int len = $urandom_range(0, 45);
      int vp  = $urandom_range(30, 95);
      int rp  = $urandom_range(10, 100);
      for (int c = 0; c < len; c++)
        rstep($urandom_range(0, 99) < vp, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < rp);
      rstep($urandom_range(0, 1) == 1, 1, $urandom_range(0, 99) < rp);
      for (int c = 0; c < 6; c++)
        rstep($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 99) < rp);
      drain(rp);
    end
    rstep(0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/fb_desc_stream_scheduler.md
Name: fb_desc_stream_scheduler

Overview:
Sits between the BRIEF descriptor generator and the downstream AXI4-Stream FIFO/matcher. It buffers descriptors in a small FIFO and applies back-pressure correctly, holding data until it is accepted rather than dropping it. It enforces a per-frame descriptor budget and sequences end-of-frame: it drains all queued descriptors, then emits exactly one tlast marker beat per frame. It also exports drop and per-frame statistics for software.

Parameters:
DESC_WIDTH, 256, descriptor bit width
COORD_WIDTH, 11, x/y coordinate width
AXIS_WIDTH, 280, stream beat width; must equal DESC_WIDTH+2*COORD_WIDTH+2
MAX_CORNERS, 1000, descriptors accepted per frame before further ones are dropped
FIFO_DEPTH, 16, descriptor queue depth; power of two, >=2

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse; closes the current frame
desc_valid  in  1  descriptor strobe (no ready; a descriptor not accepted is dropped)
desc_data  in  DESC_WIDTH  descriptor bits
desc_x  in  COORD_WIDTH  corner x
desc_y  in  COORD_WIDTH  corner y
m_axis_tdata  out  AXIS_WIDTH  {2'b00, y, x, desc}, or marker payload
m_axis_tvalid  out  1  beat valid
m_axis_tlast  out  1  end-of-frame marker beat
m_axis_tready  in  1  downstream ready
dropped_count  out  16  saturating count of dropped descriptors since reset
frame_corner_count  out  clog2(MAX_CORNERS+1)  descriptors accepted in the last closed frame
busy  out  1  high in DRAIN or EOF

Behaviour:
- Reset (async assert, sync release): FSM=STREAM, FIFO empty, budget counter 0; all outputs 0.
- FSM states:
  - STREAM: on frame_start -> DRAIN.
  - DRAIN: when FIFO is empty -> EOF.
  - EOF: on the m_axis_tready handshake -> STREAM.
  - Leaving EOF: latch budget counter into frame_corner_count and clear the budget counter in the same cycle.
  - frame_start in DRAIN/EOF: ignored; there is no pending flag.
- Accept rule: push when desc_valid && state==STREAM && !full && budget<MAX_CORNERS. The budget counter increments on each push.
- Drop rule: any desc_valid not pushed increments dropped_count; it saturates at 16'hFFFF.
- Simultaneous frame_start and desc_valid in STREAM: the descriptor is judged under STREAM rules (accepted if allowed); the transition takes effect next cycle.
- Full evaluated pre-pop: push is rejected when full, even if a pop occurs in the same cycle.
- FIFO: registered read, not fall-through. A descriptor pushed in cycle N can first appear on tdata in cycle N+1.
- Data output (STREAM/DRAIN):
  - tvalid = !fifo_empty; tlast = 0.
  - Pop on tvalid && tready.
  - tdata is held stable while tvalid && !tready.
- Marker output (EOF): tvalid=1, tlast=1, tdata=0 (see optional feature); held until tready.
- AXIS compliance: tvalid never deasserts without a handshake; tdata is 0 whenever tvalid=0.
- Budget counter width is clog2(MAX_CORNERS+1); the counter never exceeds MAX_CORNERS.
- Back-pressure never affects the upstream pipeline; overflow is accounted only through dropped_count.
- Reset mid-frame: the queue is discarded, no marker is sent, and dropped_count is cleared.

Optional Feature:
Macro FB_STREAM_FRAME_ID_EN.
- Defined: an 8-bit frame_id counter increments (wrapping) on every marker handshake. The marker beat carries tdata[7:0]=frame_id, tdata[17:8]=frame's accepted count (zero-extended to 10 bits, clipped), all other bits 0.
- Undefined: the counter does not exist and the marker tdata is all zero.

Decomposition:
- Package fb_stream_pkg:
  - desc_beat_t packed struct {pad[1:0], y, x, desc}
  - sched_state_t enum {STREAM, DRAIN, EOF}
  - AXIS_WIDTH consistency localparam
  - EOF marker field offsets
- Sub-module fb_desc_fifo: synchronous FIFO of desc_beat_t with full/empty and registered head.

Test Plan:
- 5 descriptors (x=1..5, y=7), tready=1, then frame_start -> 5 beats in order with tlast=0, then 1 beat tlast=1 tdata=0; frame_corner_count=5.
- tready=0 for 40 cycles while 20 descriptors arrive (FIFO_DEPTH=16) -> 16 queued, dropped_count=4; tdata constant during stall; 16 beats after release.
- MAX_CORNERS=3 override, 6 descriptors with tready=1 -> 3 beats out, dropped_count=3; after the next marker, 2 new descriptors both pass.
- frame_start with 4 queued and tready toggling 1/0 -> all 4 beats precede the single tlast beat; a second frame_start during DRAIN yields no extra marker; descriptors during DRAIN are counted as dropped.
- rst_n asserted mid-DRAIN with 3 queued -> tvalid=0 immediately (async), no marker after release, counters=0.
- With FB_STREAM_FRAME_ID_EN, three frames of 2 descriptors each -> marker tdata[7:0]=0,1,2 and tdata[17:8]=2 each.
